// File: rtl/assembly_sequencer.sv
// Two-pass source walker: pass 1 feeds characters to the assembler for PC mapping and counts
// instruction lines, pass 2 re-feeds them and writes each verdict into instruction memory.
module assembly_sequencer #(
  parameter int CHAR_PER_LINE = 64,
  parameter int MAX_INST      = 1024,
  parameter int TIMEOUT       = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start,
  input  logic [15:0]                 src_length,
  output logic [15:0]                 src_addr,
  input  logic [7:0]                  src_data,
  output logic                        new_character,
  output logic                        new_line,
  output logic [7:0]                  incoming_character,
  output logic [1:0]                  asm_state,
  input  logic                        done_flag,
  input  logic                        error_flag,
  input  logic [31:0]                 instruction,
  output logic                        imem_we,
  output logic [$clog2(MAX_INST)-1:0] imem_addr,
  output logic [31:0]                 imem_data,
  output logic                        busy,
  output logic                        finished,
  output logic                        error,
  output logic [15:0]                 error_line,
  output logic [15:0]                 inst_count
);

  localparam int          AW        = $clog2(MAX_INST);
  localparam logic [15:0] LINE_MAX  = 16'(CHAR_PER_LINE);
  localparam logic [15:0] INST_MAX  = 16'(MAX_INST);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, P1_FETCH, P1_FEED, P1_END, P2_FETCH, P2_FEED, P2_WAIT, DONE, ERR
  } state_t;

  state_t          state;
  logic [15:0]     ptr, line, line_len, count, timer;
  logic [AW-1:0]   pc;
  logic            nonblank, synth, restart;

  logic p1, last, is_lf, is_cr, is_space;
  assign p1       = (state == P1_FEED);
  assign last     = (ptr == src_length - 16'd1);
  assign is_lf    = (src_data == 8'h0A);
  assign is_cr    = (src_data == 8'h0D);
  assign is_space = (src_data == 8'h20) || (src_data == 8'h09);

  assign src_addr = ptr;
  assign busy     = !(state inside {IDLE, DONE, ERR});
  assign finished = (state == DONE);
  assign error    = (state == ERR);

  always_comb begin
    asm_state = 2'd0;
    case (state)
      P1_FETCH, P1_FEED, P1_END: asm_state = 2'd1;
      P2_FETCH, P2_FEED, P2_WAIT: asm_state = 2'd2;
      ERR:                        asm_state = 2'd3;
      default:                    asm_state = 2'd0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= IDLE;
      ptr                <= '0;
      line               <= '0;
      line_len           <= '0;
      count              <= '0;
      timer              <= '0;
      pc                 <= '0;
      nonblank           <= 1'b0;
      synth              <= 1'b0;
      restart            <= 1'b0;
      new_character      <= 1'b0;
      new_line           <= 1'b0;
      incoming_character <= '0;
      imem_we            <= 1'b0;
      imem_addr          <= '0;
      imem_data          <= '0;
      error_line         <= '0;
      inst_count         <= '0;
    end else begin
      new_character <= 1'b0;
      new_line      <= 1'b0;
      imem_we       <= 1'b0;
      case (state)
        IDLE: if (start || restart) begin
          restart    <= 1'b0;
          ptr        <= '0;
          line       <= 16'd1;
          line_len   <= '0;
          count      <= '0;
          pc         <= '0;
          inst_count <= '0;
          error_line <= '0;
          nonblank   <= 1'b0;
          synth      <= 1'b0;
          state      <= (src_length == 16'd0) ? DONE : P1_FETCH;
        end
        P1_FETCH: begin
          if (error_flag) begin error_line <= line; state <= ERR; end
          else state <= P1_FEED;
        end
        P2_FETCH: state <= P2_FEED;
        P1_FEED, P2_FEED: begin
          if (p1 && error_flag) begin
            error_line <= line;
            state      <= ERR;
          end else if (synth || is_lf) begin
            // synth marks the implied terminator after an unterminated final line
            if (p1 && nonblank && count == INST_MAX) begin
              error_line <= line;
              state      <= ERR;
            end else begin
              new_line <= 1'b1;
              line     <= line + 16'd1;
              line_len <= '0;
              nonblank <= 1'b0;
              synth    <= 1'b0;
              if (p1 && nonblank) count <= count + 16'd1;
              if (!p1 && nonblank) begin
                timer <= '0;
                state <= P2_WAIT;
              end else if (synth || last) begin
                state <= p1 ? P1_END : DONE;
              end else begin
                ptr   <= ptr + 16'd1;
                state <= p1 ? P1_FETCH : P2_FETCH;
              end
            end
          end else if (is_cr) begin
            if (!last) begin
              ptr   <= ptr + 16'd1;
              state <= p1 ? P1_FETCH : P2_FETCH;
            end else if (line_len != 16'd0) begin
              synth <= 1'b1;
            end else begin
              state <= p1 ? P1_END : DONE;
            end
          end else if (p1 && line_len == LINE_MAX) begin
            error_line <= line;
            state      <= ERR;
          end else begin
            new_character      <= 1'b1;
            incoming_character <= src_data;
            line_len           <= line_len + 16'd1;
            if (!is_space) nonblank <= 1'b1;
            if (last) begin
              synth <= 1'b1;
            end else begin
              ptr   <= ptr + 16'd1;
              state <= p1 ? P1_FETCH : P2_FETCH;
            end
          end
        end
        P1_END: begin
          if (error_flag) begin
            error_line <= line;
            state      <= ERR;
          end else begin
            ptr      <= '0;
            line     <= 16'd1;
            line_len <= '0;
            nonblank <= 1'b0;
            synth    <= 1'b0;
            state    <= P2_FETCH;
          end
        end
        P2_WAIT: begin
          // line already advanced on the terminator, so the waited-on line is line-1
          if (error_flag) begin
            error_line <= line - 16'd1;
            state      <= ERR;
          end else if (done_flag) begin
            imem_we    <= 1'b1;
            imem_addr  <= pc;
            imem_data  <= instruction;
            pc         <= pc + 1'b1;
            inst_count <= inst_count + 16'd1;
            if (last) begin
              state <= DONE;
            end else begin
              ptr   <= ptr + 16'd1;
              state <= P2_FETCH;
            end
          end else if (timer == WAIT_LAST) begin
            error_line <= line - 16'd1;
            state      <= ERR;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        DONE, ERR: if (start) begin
          restart <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assembly_sequencer.sv
// Directed bench for assembly_sequencer: text memory model, assembler responder, imem write log.
module tb_assembly_sequencer;

  logic        clk_in = 1'b0, rst_in = 1'b1, start = 1'b0;
  logic [15:0] src_length = '0;
  logic [15:0] src_addr;
  logic [7:0]  src_data = '0;
  logic        new_character, new_line;
  logic [7:0]  incoming_character;
  logic [1:0]  asm_state;
  logic        done_flag = 1'b0, error_flag = 1'b0;
  logic [31:0] instruction = '0;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        busy, finished, error;
  logic [15:0] error_line, inst_count;

  assembly_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .src_length(src_length),
    .src_addr(src_addr), .src_data(src_data), .new_character(new_character),
    .new_line(new_line), .incoming_character(incoming_character), .asm_state(asm_state),
    .done_flag(done_flag), .error_flag(error_flag), .instruction(instruction),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .busy(busy), .finished(finished), .error(error),
    .error_line(error_line), .inst_count(inst_count)
  );

  always #5 clk_in = ~clk_in;

  int compared = 0, mismatched = 0;
  logic [7:0] mem [0:255];
  int resp_delay = 2, resp_err_line = 0;
  bit resp_silent = 1'b0;
  logic [31:0] resp_base = 32'h00500093;
  int wcount = 0, p1c = 0, p1n = 0, p2c = 0, p2n = 0, viol = 0, cur_pass = 0;
  logic [9:0]  waddr [0:15];
  logic [31:0] wdata [0:15];

  // text buffer: data for the address seen in one cycle appears in the next
  initial begin
    logic [15:0] a;
    forever begin
      @(negedge clk_in); a = src_addr;
      @(posedge clk_in); #1; src_data = mem[a[7:0]];
    end
  end

  // assembler model: answers each non-blank pass-2 line after resp_delay cycles
  initial begin
    int cd, p2_line, r_idx, pend_line;
    bit line_nb;
    cd = 0; p2_line = 1; r_idx = 0; pend_line = 0; line_nb = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      done_flag = 1'b0; error_flag = 1'b0;
      if (rst_in || asm_state == 2'd1) begin
        cd = 0; p2_line = 1; r_idx = 0; line_nb = 1'b0;
      end else if (asm_state == 2'd2 || cd != 0) begin
        if (cd != 0) begin
          cd--;
          if (cd == 0) begin
            if (pend_line == resp_err_line) error_flag = 1'b1;
            else if (!resp_silent) begin
              done_flag = 1'b1; instruction = resp_base + 32'(r_idx); r_idx++;
            end
          end
        end
        if (new_character && incoming_character != 8'h20 && incoming_character != 8'h09) line_nb = 1'b1;
        if (new_line) begin
          if (line_nb) begin cd = resp_delay; pend_line = p2_line; end
          p2_line++; line_nb = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (asm_state == 2'd1) cur_pass = 1; else if (asm_state == 2'd2) cur_pass = 2;
    if (new_character) begin if (cur_pass == 1) p1c++; else p2c++; end
    if (new_line)      begin if (cur_pass == 1) p1n++; else p2n++; end
    if (imem_we) begin
      if (wcount < 16) begin waddr[wcount] = imem_addr; wdata[wcount] = imem_data; end
      wcount++;
    end
    if ((new_character && new_line) || (imem_we && (new_character || new_line))) viol++;
  end

  task automatic clear_log();
    wcount = 0; p1c = 0; p1n = 0; p2c = 0; p2n = 0;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    src_length = 16'(s.len());
  endtask

  task automatic load_fill(input int n);
    for (int i = 0; i < n; i++) mem[i] = 8'h61;
    mem[n] = 8'h0A;
    src_length = 16'(n + 1);
  endtask

  task automatic pulse_start();
    clear_log();
    @(posedge clk_in); #1 start = 1'b1;
    @(posedge clk_in); #1 start = 1'b0;
  endtask

  task automatic run(output bit ok);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if (finished || error) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk_in); @(negedge clk_in);
    compared++; if ({busy, finished, error} !== 3'b000) begin mismatched++; $display("FAIL reset_status: got %b want 000", {busy, finished, error}); end
    compared++; if (asm_state !== 2'd0) begin mismatched++; $display("FAIL reset_asm_state: got %0d want 0", asm_state); end
    compared++; if ({new_character, new_line, imem_we} !== 3'b000) begin mismatched++; $display("FAIL reset_strobes: got %b want 000", {new_character, new_line, imem_we}); end
    compared++; if ({src_addr, imem_addr, imem_data, incoming_character, error_line, inst_count} !== '0) begin mismatched++; $display("FAIL reset_buses: src_addr %0h imem_addr %0h imem_data %0h char %0h error_line %0d inst_count %0d want all 0", src_addr, imem_addr, imem_data, incoming_character, error_line, inst_count); end
    @(posedge clk_in); #1 rst_in = 1'b0;
  endtask

  task automatic test_single_line();
    bit ok;
    load_str("addi x1, x0, 5\n");
    run(ok);
    compared++; if (ok !== 1'b1 || finished !== 1'b1 || error !== 1'b0) begin mismatched++; $display("FAIL single_finish: finished %0b error %0b want 1 0", finished, error); end
    compared++; if (wcount !== 1 || waddr[0] !== 10'd0 || wdata[0] !== 32'h00500093) begin mismatched++; $display("FAIL single_write: count %0d addr %0d data %h want 1 0 00500093", wcount, waddr[0], wdata[0]); end
    compared++; if (inst_count !== 16'd1 || busy !== 1'b0) begin mismatched++; $display("FAIL single_inst_count: got %0d busy %0b want 1 0", inst_count, busy); end
    compared++; if (p1c !== 14 || p1n !== 1 || p2c !== 14 || p2n !== 1) begin mismatched++; $display("FAIL single_strobes: p1 %0d/%0d p2 %0d/%0d want 14/1 14/1", p1c, p1n, p2c, p2n); end
  endtask

  task automatic test_blank_line();
    bit ok;
    load_str("nop\n\nnop");
    run(ok);
    compared++; if (ok !== 1'b1 || finished !== 1'b1) begin mismatched++; $display("FAIL blank_finish: finished %0b want 1", finished); end
    compared++; if (wcount !== 2 || waddr[0] !== 10'd0 || waddr[1] !== 10'd1) begin mismatched++; $display("FAIL blank_addrs: count %0d addr %0d %0d want 2 0 1", wcount, waddr[0], waddr[1]); end
    compared++; if (wdata[1] !== 32'h00500094 || inst_count !== 16'd2) begin mismatched++; $display("FAIL blank_data: data %h count %0d want 00500094 2", wdata[1], inst_count); end
    compared++; if (p1n !== 3 || p2n !== 3 || p1c !== 6) begin mismatched++; $display("FAIL blank_synth_newline: p1n %0d p2n %0d p1c %0d want 3 3 6", p1n, p2n, p1c); end
  endtask

  task automatic test_crlf_whitespace();
    bit ok;
    load_str(" \t\015\nnop");
    run(ok);
    compared++; if (ok !== 1'b1 || wcount !== 1 || inst_count !== 16'd1) begin mismatched++; $display("FAIL crlf_writes: count %0d inst %0d want 1 1", wcount, inst_count); end
    compared++; if (p2c !== 5 || p2n !== 2) begin mismatched++; $display("FAIL crlf_strobes: p2c %0d p2n %0d want 5 2", p2c, p2n); end
  endtask

  task automatic test_verdict_error();
    bit ok;
    resp_err_line = 2;
    load_str("nop\nbad\nnop\n");
    run(ok);
    resp_err_line = 0;
    compared++; if (ok !== 1'b1 || error !== 1'b1 || asm_state !== 2'd3) begin mismatched++; $display("FAIL verr_state: error %0b asm_state %0d want 1 3", error, asm_state); end
    compared++; if (error_line !== 16'd2) begin mismatched++; $display("FAIL verr_line: got %0d want 2", error_line); end
    compared++; if (wcount !== 1 || inst_count !== 16'd1) begin mismatched++; $display("FAIL verr_writes: count %0d inst %0d want 1 1", wcount, inst_count); end
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    resp_silent = 1'b1;
    load_str("nop\n");
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (asm_state == 2'd2 && new_line) begin seen = 1'b1; break; end
    end
    n = 0;
    if (seen) for (int i = 0; i < 100; i++) begin
      @(negedge clk_in); n++;
      if (error) break;
    end
    resp_silent = 1'b0;
    compared++; if (seen !== 1'b1 || n !== 16) begin mismatched++; $display("FAIL timeout_cycles: seen %0b cycles %0d want 1 16", seen, n); end
    compared++; if (error_line !== 16'd1 || wcount !== 0) begin mismatched++; $display("FAIL timeout_line: line %0d writes %0d want 1 0", error_line, wcount); end
  endtask

  task automatic test_long_line();
    bit ok;
    load_fill(65);
    run(ok);
    compared++; if (ok !== 1'b1 || error !== 1'b1 || error_line !== 16'd1) begin mismatched++; $display("FAIL long_error: error %0b line %0d want 1 1", error, error_line); end
    compared++; if (src_addr !== 16'd64 || p1c !== 64 || wcount !== 0) begin mismatched++; $display("FAIL long_where: addr %0d chars %0d writes %0d want 64 64 0", src_addr, p1c, wcount); end
  endtask

  task automatic test_max_line();
    bit ok;
    load_fill(64);
    run(ok);
    compared++; if (ok !== 1'b1 || finished !== 1'b1 || wcount !== 1) begin mismatched++; $display("FAIL maxline: finished %0b writes %0d want 1 1", finished, wcount); end
  endtask

  task automatic test_reset_midpass();
    bit seen, ok;
    load_str("nop\nnop\n");
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (asm_state == 2'd2 && new_character) begin seen = 1'b1; break; end
    end
    @(posedge clk_in); #1 rst_in = 1'b1;
    #1;
    compared++; if (seen !== 1'b1 || asm_state !== 2'd0 || busy !== 1'b0 || src_addr !== 16'd0) begin mismatched++; $display("FAIL rst_mid_zero: seen %0b asm %0d busy %0b addr %0d want 1 0 0 0", seen, asm_state, busy, src_addr); end
    repeat (3) @(negedge clk_in);
    compared++; if (wcount !== 0 || imem_we !== 1'b0 || inst_count !== 16'd0) begin mismatched++; $display("FAIL rst_mid_nowrite: writes %0d we %0b inst %0d want 0 0 0", wcount, imem_we, inst_count); end
    @(posedge clk_in); #1 rst_in = 1'b0;
    run(ok);
    compared++; if (ok !== 1'b1 || finished !== 1'b1 || wcount !== 2 || wdata[1] !== 32'h00500094 || inst_count !== 16'd2) begin mismatched++; $display("FAIL rst_mid_rerun: fin %0b writes %0d data %h inst %0d want 1 2 00500094 2", finished, wcount, wdata[1], inst_count); end
  endtask

  task automatic test_strobe_rules();
    compared++; if (viol !== 0) begin mismatched++; $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_blank_line();
    test_crlf_whitespace();
    test_verdict_error();
    test_timeout();
    test_long_line();
    test_max_line();
    test_reset_midpass();
    test_strobe_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
